// File: rtl/demixer_iq.sv
// Purpose: fs/4 digital demixer of a real sample stream into I/Q, followed by
//          a block-average decimator by N = 2**DECIM_LOG2.
// Latency: the result register loads on the edge that accepts the last sample of a block.
// Backpressure: ready_i only consumes the held pair; a new result always loads and sets ovr_o when the old pair was unconsumed.
// Ports:
//   clk, rst           clock and async active-high reset
//   demixin_i/valid_i  signed 15-bit real input sample and its qualifier
//   phase_rst_i        synchronous restart of LO phase and decimation block
//   ready_i            downstream takes the output pair
//   clr_ovr_i          synchronous clear of the sticky overrun flag
//   LO_i_o/LO_q_o      LO codes {neg,pos} for the next accepted sample
//   out_i_o/out_q_o    decimated signed 15-bit I/Q results, qualified by valid_o
//   ovr_o              sticky overrun flag
module demixer_iq #(
  parameter int DECIM_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [14:0] demixin_i,
  input  logic               valid_i,
  input  logic               phase_rst_i,
  input  logic               ready_i,
  input  logic               clr_ovr_i,
  output logic [1:0]         LO_i_o,
  output logic [1:0]         LO_q_o,
  output logic signed [14:0] out_i_o,
  output logic signed [14:0] out_q_o,
  output logic               valid_o,
  output logic               ovr_o
);

  localparam int AW = 16 + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

  logic [DECIM_LOG2-1:0] cnt;
  logic [1:0]            phase;
  logic signed [15:0]    x16;
  logic signed [15:0]    x16_neg;
  logic signed [15:0]    prod_i;
  logic signed [15:0]    prod_q;
  logic signed [AW-1:0]  acc_i;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  sum_i;
  logic signed [AW-1:0]  sum_q;
  logic                  accept;
  logic                  last_smp;

  assign phase    = cnt[1:0];
  assign accept   = valid_i & ~phase_rst_i;
  assign last_smp = accept & (cnt == CNT_LAST);

  // One extra bit so that negating -16384 yields +16384 instead of wrapping.
  assign x16     = {demixin_i[14], demixin_i};
  assign x16_neg = -x16;

  // LO sequence cos/-sin at fs/4: I = +1,0,-1,0 and Q = 0,-1,0,+1.
  always_comb begin
    prod_i = '0;
    prod_q = '0;
    LO_i_o = 2'b00;
    LO_q_o = 2'b00;
    case (phase)
      2'd0: begin prod_i = x16;     LO_i_o = 2'b01; end
      2'd1: begin prod_q = x16_neg; LO_q_o = 2'b10; end
      2'd2: begin prod_i = x16_neg; LO_i_o = 2'b10; end
      default: begin prod_q = x16;  LO_q_o = 2'b01; end
    endcase
  end

  assign sum_i = acc_i + {{DECIM_LOG2{prod_i[15]}}, prod_i};
  assign sum_q = acc_q + {{DECIM_LOG2{prod_q[15]}}, prod_q};

  // Counter and accumulators. The counter wraps to 0 naturally on the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (phase_rst_i) begin
      cnt   <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      if (last_smp) begin
        acc_i <= '0;
        acc_q <= '0;
      end else begin
        acc_i <= sum_i;
        acc_q <= sum_q;
      end
    end
  end

  // Output pair. Only half the block's samples are nonzero per channel, so the
  // average is sum >>> (DECIM_LOG2-1). Taking 15 bits starting at that bit is
  // the floor shift plus truncation; the range bound makes the truncation safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_i_o <= '0;
      out_q_o <= '0;
      valid_o <= 1'b0;
      ovr_o   <= 1'b0;
    end else begin
      if (last_smp) begin
        out_i_o <= sum_i[DECIM_LOG2-1 +: 15];
        out_q_o <= sum_q[DECIM_LOG2-1 +: 15];
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      // Overwriting an unconsumed pair takes priority over a clear request.
      if (last_smp && valid_o && !ready_i) begin
        ovr_o <= 1'b1;
      end else if (clr_ovr_i) begin
        ovr_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demixer_iq.sv
// Purpose: directed self-checking bench for demixer_iq with DECIM_LOG2 = 2.
// Latency: results are checked 1 time unit after the edge accepting a block's last sample.
// Backpressure: ready_i is driven per sample to exercise hold, consume and overrun cases.
module tb_demixer_iq;

  logic               clk;
  logic               rst;
  logic signed [14:0] demixin_i;
  logic               valid_i;
  logic               phase_rst_i;
  logic               ready_i;
  logic               clr_ovr_i;
  logic [1:0]         LO_i_o;
  logic [1:0]         LO_q_o;
  logic signed [14:0] out_i_o;
  logic signed [14:0] out_q_o;
  logic               valid_o;
  logic               ovr_o;

  int checks = 0;
  int errors = 0;

  demixer_iq #(.DECIM_LOG2(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .demixin_i   (demixin_i),
    .valid_i     (valid_i),
    .phase_rst_i (phase_rst_i),
    .ready_i     (ready_i),
    .clr_ovr_i   (clr_ovr_i),
    .LO_i_o      (LO_i_o),
    .LO_q_o      (LO_q_o),
    .out_i_o     (out_i_o),
    .out_q_o     (out_q_o),
    .valid_o     (valid_o),
    .ovr_o       (ovr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted sample; inputs change 1 unit after the edge, away from it.
  task automatic send(input logic signed [14:0] x, input logic rdy);
    demixin_i = x;
    valid_i   = 1'b1;
    ready_i   = rdy;
    @(posedge clk);
    #1;
    valid_i   = 1'b0;
  endtask

  // Idle cycles with junk data on the bus.
  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      demixin_i = 15'($urandom);
      valid_i   = 1'b0;
      ready_i   = rdy;
      @(posedge clk);
      #1;
    end
  endtask

  // Reference for one N=4 block: I = (s0 - s2)/2, Q = (s3 - s1)/2, floor.
  task automatic model(input int s0, input int s1, input int s2, input int s3, output int ei, output int eq);
    ei = (s0 - s2) >>> 1;
    eq = (s3 - s1) >>> 1;
  endtask

  task automatic expect_pair(input string tag, input int ei, input int eq);
    chk({tag, "_valid"}, valid_o, 1);
    chk({tag, "_i"}, out_i_o, ei);
    chk({tag, "_q"}, out_q_o, eq);
  endtask

  initial begin : stim
    int s[4];
    int ei;
    int eq;
    int last_i;
    int last_q;

    rst = 1'b1; demixin_i = '0; valid_i = 1'b0; phase_rst_i = 1'b0;
    ready_i = 1'b1; clr_ovr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_i", out_i_o, 0);
    chk("rst_out_q", out_q_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ovr", ovr_o, 0);
    chk("rst_lo_i", LO_i_o, 1);
    chk("rst_lo_q", LO_q_o, 0);
    rst = 1'b0;
    idle(1, 1'b1);

    // DC input cancels in both channels; LO codes walk through all phases.
    send(500, 1'b1);
    chk("lo_p1_i", LO_i_o, 0);
    chk("lo_p1_q", LO_q_o, 2);
    send(500, 1'b1);
    chk("lo_p2_i", LO_i_o, 2);
    chk("lo_p2_q", LO_q_o, 0);
    send(500, 1'b1);
    chk("lo_p3_i", LO_i_o, 0);
    chk("lo_p3_q", LO_q_o, 1);
    chk("dc_not_yet", valid_o, 0);
    send(500, 1'b1);
    expect_pair("dc1", 0, 0);
    chk("lo_wrap_i", LO_i_o, 1);
    send(500, 1'b1);
    chk("dc_consumed", valid_o, 0);
    send(500, 1'b1);
    send(500, 1'b1);
    send(500, 1'b1);
    expect_pair("dc2", 0, 0);

    // Cosine and sine tones at fs/4.
    send(1000, 1'b1); send(0, 1'b1); send(-1000, 1'b1); send(0, 1'b1);
    expect_pair("cos", 1000, 0);
    send(0, 1'b1); send(1000, 1'b1); send(0, 1'b1); send(-1000, 1'b1);
    expect_pair("sin", 0, -1000);

    // Full-scale extremes must not wrap.
    send(16383, 1'b1); send(7, 1'b1); send(-16384, 1'b1); send(-5, 1'b1);
    expect_pair("ext_pos", 16383, -6);
    send(-16384, 1'b1); send(3, 1'b1); send(16383, 1'b1); send(9, 1'b1);
    expect_pair("ext_neg", -16384, 3);
    idle(1, 1'b1);
    chk("ext_consumed", valid_o, 0);

    // Backpressure: hold, overwrite with overrun, clear.
    send(100, 1'b0); send(0, 1'b0); send(0, 1'b0); send(0, 1'b0);
    expect_pair("bp_a", 50, 0);
    chk("bp_a_ovr", ovr_o, 0);
    idle(2, 1'b0);
    expect_pair("bp_hold", 50, 0);
    send(0, 1'b0); send(0, 1'b0); send(-300, 1'b0); send(0, 1'b0);
    expect_pair("bp_b", 150, 0);
    chk("bp_b_ovr", ovr_o, 1);
    idle(1, 1'b1);
    chk("bp_b_taken", valid_o, 0);
    chk("bp_ovr_sticky", ovr_o, 1);
    clr_ovr_i = 1'b1;
    idle(1, 1'b0);
    clr_ovr_i = 1'b0;
    chk("bp_ovr_clr", ovr_o, 0);

    send(0, 1'b0); send(10, 1'b0); send(0, 1'b0); send(0, 1'b0);
    expect_pair("bp_c", 0, -5);
    chk("bp_c_ovr", ovr_o, 0);
    send(-7, 1'b0); send(0, 1'b0); send(0, 1'b0);
    clr_ovr_i = 1'b1;
    send(0, 1'b0);
    clr_ovr_i = 1'b0;
    expect_pair("bp_d_floor", -4, 0);
    chk("bp_set_wins", ovr_o, 1);
    clr_ovr_i = 1'b1;
    idle(1, 1'b0);
    clr_ovr_i = 1'b0;
    chk("bp_ovr_clr2", ovr_o, 0);
    chk("bp_d_still", valid_o, 1);
    send(0, 1'b0); send(0, 1'b0); send(0, 1'b0); send(-50, 1'b1);
    expect_pair("bp_e", 0, -25);
    chk("bp_e_no_ovr", ovr_o, 0);

    // Random gaps between samples must be transparent.
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) begin
        s[k] = int'($urandom_range(32767)) - 16384;
        idle(int'($urandom_range(3)), 1'b1);
        send(15'(s[k]), 1'b1);
      end
      model(s[0], s[1], s[2], s[3], ei, eq);
      expect_pair("gap", ei, eq);
    end
    last_i = ei;
    last_q = eq;

    // phase_rst mid-block: partial sum discarded, outputs untouched.
    send(3000, 1'b0); send(-2000, 1'b0);
    demixin_i = 15'(12345); valid_i = 1'b1; phase_rst_i = 1'b1; ready_i = 1'b0;
    @(posedge clk);
    #1;
    valid_i = 1'b0; phase_rst_i = 1'b0;
    expect_pair("prst_hold", last_i, last_q);
    chk("prst_lo_i", LO_i_o, 1);
    chk("prst_lo_q", LO_q_o, 0);
    send(40, 1'b1); send(-60, 1'b1); send(-20, 1'b1); send(80, 1'b1);
    model(40, -60, -20, 80, ei, eq);
    expect_pair("prst_blk", ei, eq);

    // Asynchronous reset mid-block.
    send(5000, 1'b0); send(6000, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_out_i", out_i_o, 0);
    chk("arst_lo_i", LO_i_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1000, 1'b1); send(-2000, 1'b1); send(3000, 1'b1); send(-4000, 1'b1);
    expect_pair("arst_blk", -1000, -1000);

    idle(2, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demixer_iq.md
DEMIXER_IQ -- requirements
Module: demixer_iq

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 2, log2 of decimation factor N=2^DECIM_LOG2; legal range 2..6.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port demixin_i  input  15  signed real input sample.
REQ-005 SHALL have port valid_i  input  1  demixin_i carries a sample this cycle.
REQ-006 SHALL have port phase_rst_i  input  1  synchronous restart of LO phase and decimation block.
REQ-007 SHALL have port ready_i  input  1  downstream accepts the current output pair.
REQ-008 SHALL have port clr_ovr_i  input  1  synchronous clear of the overrun flag.
REQ-009 SHALL have port LO_i_o  output  2  I-LO code for the next accepted sample: {neg,pos}, 00 means zero.
REQ-010 SHALL have port LO_q_o  output  2  Q-LO code for the next accepted sample, same encoding.
REQ-011 SHALL have port out_i_o  output  15  signed decimated I result.
REQ-012 SHALL have port out_q_o  output  15  signed decimated Q result.
REQ-013 SHALL have port valid_o  output  1  out_i_o/out_q_o hold an unconsumed pair.
REQ-014 SHALL have port ovr_o  output  1  sticky overrun flag.

Function
REQ-015 SHALL keep a sample counter of DECIM_LOG2 bits; it advances by 1 (wrapping) on each accepted sample, where accepted means valid_i=1 and phase_rst_i=0.
REQ-016 SHALL take LO phase p as counter[1:0]: p0 I=+1 Q=0; p1 I=0 Q=-1; p2 I=-1 Q=0; p3 I=0 Q=+1.
REQ-017 SHALL drive LO_i_o and LO_q_o combinationally from the current phase: +1=01, -1=10, 0=00.
REQ-018 SHALL form each product in 16 bits: +x, -x or 0; -(-16384) SHALL give +16384 without wrap.
REQ-019 SHALL keep per-channel signed accumulators of 16+DECIM_LOG2 bits and add each accepted product.
REQ-020 SHALL, on the accepted sample with counter = N-1, compute final sum = accumulator + product, arithmetic shift right by DECIM_LOG2-1 (floor), truncate to 15 bits into the output registers, and clear the accumulators in the same cycle.
REQ-021 SHALL never overflow the truncation in REQ-020 for any input; results SHALL lie in [-16384, 16383].
REQ-022 SHALL present results one cycle after the last sample of the block: out registers and valid_o=1 on the next edge.
REQ-023 SHALL hold out_i_o, out_q_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-024 SHALL clear valid_o when valid_o=1 and ready_i=1, unless a new result loads in the same cycle.
REQ-025 SHALL, if a new result completes while valid_o=1 and ready_i=0, overwrite the outputs, keep valid_o=1 and set ovr_o.
REQ-026 SHALL, if a new result completes while valid_o=1 and ready_i=1, load it with valid_o=1 and leave ovr_o unchanged.
REQ-027 SHALL clear ovr_o on clr_ovr_i=1; a same-cycle set SHALL win over the clear.
REQ-028 SHALL, on phase_rst_i=1, zero the counter and accumulators and discard any valid_i sample that cycle; output registers, valid_o and ovr_o SHALL be unaffected.
REQ-029 SHALL not change counter, phase or accumulators on cycles with valid_i=0; gaps SHALL be transparent.

Reset
REQ-030 SHALL, while rst=1, force counter=0, accumulators=0, out_i_o=0, out_q_o=0, valid_o=0, ovr_o=0, hence LO_i_o=01, LO_q_o=00.
REQ-031 SHALL abandon a partially accumulated block on reset; the first post-reset accepted sample SHALL be phase p0.

Verification
REQ-032 Bench SHALL cover, with DECIM_LOG2=2: DC input 500 on every cycle -> every pair I=0, Q=0, valid_o pulses every 4 samples.
REQ-033 Bench SHALL cover a cosine input 1000,0,-1000,0 repeated -> I=1000, Q=0; a sine input 0,1000,0,-1000 -> I=0, Q=-1000.
REQ-034 Bench SHALL cover extremes 16383,x,-16384,x -> I=16383; -16384,x,16383,x -> I=-16384; no wrap.
REQ-035 Bench SHALL cover ready_i=0 across two completed blocks -> second pair shown, ovr_o=1 until clr_ovr_i; with ready_i=1 on the load cycle -> ovr_o stays 0.
REQ-036 Bench SHALL cover random valid_i gaps plus phase_rst_i or rst mid-block -> results match a gap-free model; the block restarts at p0 and partial sums are discarded.
